// File: rtl/modmul_pkg.sv
// Shared constants, types and cycle schedule for the modular-multiplier sequencer.
package modmul_pkg;

   localparam int unsigned NUM_WORDS = 17;
   localparam int unsigned WORD_W    = 17;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned CNT_W     = $clog2(2 * NUM_WORDS + 5);

   // Cycle schedule relative to the first cycle after start is accepted.
   localparam int unsigned MUL_CYC     = 2 * NUM_WORDS - 15;
   localparam int unsigned UNLOAD_CYC  = MUL_CYC + 1;
   localparam int unsigned LAST_WR_SRC = UNLOAD_CYC + NUM_WORDS - 1;
   localparam int unsigned DONE_CYC    = 2 * NUM_WORDS + 4;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MUL,
      UNLOAD,
      DONE
   } seq_state_e;

endpackage

// File: rtl/modmul_seq.sv
// Streams operands MS word first into the serial modmul shell, pulses sout,
// then writes the rotating result stream back by word index.
module modmul_seq
   import modmul_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [WORD_W-1:0] rd_data_a,
   input  logic [WORD_W-1:0] rd_data_b,
   output logic [WORD_W-1:0] din1,
   output logic [WORD_W-1:0] din2,
   output logic              sout,
   input  logic [WORD_W-1:0] dout,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data
);

   seq_state_e state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   addr_t      rd_addr_q, rd_addr_d;
   word_t      din1_q, din1_d;
   word_t      din2_q, din2_d;
   logic       sout_q, sout_d;
   logic       wr_en_q, wr_en_d;
   addr_t      wr_addr_q, wr_addr_d;
   word_t      wr_data_q, wr_data_d;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_addr_q <= '0;
         din1_q    <= '0;
         din2_q    <= '0;
         sout_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_addr_q <= rd_addr_d;
         din1_q    <= din1_d;
         din2_q    <= din2_d;
         sout_q    <= sout_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Next-state and next-output logic; every _d value is what appears next cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rd_addr_d = '0;
      din1_d    = '0;
      din2_d    = '0;
      sout_d    = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD;
               cnt_d     = '0;
               busy_d    = 1'b1;
               rd_addr_d = addr_t'(NUM_WORDS - 1);
            end
         end

         LOAD: begin
            cnt_d = cnt_q + cnt_t'(1);
            if (cnt_q <= cnt_t'(NUM_WORDS - 2)) begin
               rd_addr_d = addr_t'(cnt_t'(NUM_WORDS - 2) - cnt_q);
            end
            // Read data lags the address by one cycle.
            if ((cnt_q >= cnt_t'(1)) && (cnt_q <= cnt_t'(NUM_WORDS))) begin
               din1_d = rd_data_a;
               din2_d = rd_data_b;
            end
            if (cnt_q == cnt_t'(MUL_CYC - 1)) begin
               state_d = MUL;
               sout_d  = 1'b1;
            end
         end

         MUL: begin
            cnt_d   = cnt_q + cnt_t'(1);
            state_d = UNLOAD;
         end

         UNLOAD: begin
            cnt_d = cnt_q + cnt_t'(1);
            // Shell emits result words in order 0, N-1, N-2, ..., 1.
            if (cnt_q <= cnt_t'(LAST_WR_SRC)) begin
               wr_en_d   = 1'b1;
               wr_data_d = dout;
               if (cnt_q == cnt_t'(UNLOAD_CYC)) begin
                  wr_addr_d = '0;
               end else begin
                  wr_addr_d = addr_t'(cnt_t'(UNLOAD_CYC + NUM_WORDS) - cnt_q);
               end
            end
            if (cnt_q == cnt_t'(DONE_CYC - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_addr = rd_addr_q;
   assign din1    = din1_q;
   assign din2    = din2_q;
   assign sout    = sout_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_modmul_seq.sv
// Bench for modmul_seq with operand RAM, XOR shell stub and write-back scoreboard.
module tb_modmul_seq;
   import modmul_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  start;
   logic  busy, done, sout, wr_en;
   addr_t rd_addr, wr_addr;
   word_t rd_data_a, rd_data_b, din1, din2, dout, wr_data;

   always #5 clk = ~clk;

   modmul_seq dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .din1(din1), .din2(din2), .sout(sout), .dout(dout),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   word_t mem_a [NUM_WORDS];
   word_t mem_b [NUM_WORDS];
   word_t res   [NUM_WORDS];
   logic [NUM_WORDS-1:0] written;
   logic clr_wr = 1'b0;

   // Synchronous operand read port.
   always @(posedge clk) begin
      rd_data_a <= (32'(rd_addr) < NUM_WORDS) ? mem_a[rd_addr] : '0;
      rd_data_b <= (32'(rd_addr) < NUM_WORDS) ? mem_b[rd_addr] : '0;
   end

   // Shell stub: shifts operands in at index 0, loads C = A ^ B on sout, then rotates.
   word_t sh_a [NUM_WORDS];
   word_t sh_b [NUM_WORDS];
   word_t sh_c [NUM_WORDS];
   always @(posedge clk) begin
      for (int i = NUM_WORDS - 1; i > 0; i--) begin
         sh_a[i] <= sh_a[i-1];
         sh_b[i] <= sh_b[i-1];
      end
      sh_a[0] <= din1;
      sh_b[0] <= din2;
      if (sout) begin
         for (int i = 0; i < NUM_WORDS; i++) sh_c[i] <= sh_a[i] ^ sh_b[i];
      end else begin
         sh_c[0] <= sh_c[NUM_WORDS-1];
         for (int i = 1; i < NUM_WORDS; i++) sh_c[i] <= sh_c[i-1];
      end
   end
   assign dout = sh_c[0];

   // Result store and write-coverage mask.
   always @(posedge clk) begin
      if (clr_wr) written <= '0;
      else if (wr_en && (32'(wr_addr) < NUM_WORDS)) begin
         written[wr_addr] <= 1'b1;
         res[wr_addr]     <= wr_data;
      end
   end

   typedef struct packed { addr_t addr; word_t data; } wr_t;
   wr_t sb [$];

   typedef struct {
      word_t a_base; word_t a_step; word_t b_base; word_t b_step;
      word_t exp_w0; word_t exp_w16;
   } vec_t;
   vec_t vecs [4];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load_vec(input vec_t v);
      for (int i = 0; i < NUM_WORDS; i++) begin
         mem_a[i] = word_t'(v.a_base + word_t'(i) * v.a_step);
         mem_b[i] = word_t'(v.b_base + word_t'(i) * v.b_step);
      end
   endtask

   task automatic push_expected();
      for (int j = 0; j < NUM_WORDS; j++) begin
         wr_t e;
         e.addr = (j == 0) ? addr_t'(0) : addr_t'(NUM_WORDS - j);
         e.data = mem_a[e.addr] ^ mem_b[e.addr];
         sb.push_back(e);
      end
   endtask

   task automatic clear_written();
      clr_wr = 1'b1;
      @(negedge clk);
      clr_wr = 1'b0;
   endtask

   // Phase k of an operation; phase 39 (or any k > 38) means idle, all outputs 0.
   task automatic check_cycle(input int k);
      int    exp_rd;
      word_t exp_d1, exp_d2;
      exp_rd = (k <= 16) ? 16 - k : 0;
      exp_d1 = (k >= 2 && k <= 18) ? mem_a[18-k] : '0;
      exp_d2 = (k >= 2 && k <= 18) ? mem_b[18-k] : '0;
      chk($sformatf("rd_addr@%0d", k), 32'(rd_addr), 32'(exp_rd));
      chk($sformatf("busy@%0d", k), 32'(busy), 32'(k <= 38));
      chk($sformatf("sout@%0d", k), 32'(sout), 32'(k == 19));
      chk($sformatf("done@%0d", k), 32'(done), 32'(k == 38));
      chk($sformatf("wr_en@%0d", k), 32'(wr_en), 32'(k >= 21 && k <= 37));
      chk($sformatf("din1@%0d", k), 32'(din1), 32'(exp_d1));
      chk($sformatf("din2@%0d", k), 32'(din2), 32'(exp_d2));
      if (wr_en) begin
         if (sb.size() == 0) begin
            chk($sformatf("unexpected_write@%0d", k), 32'(wr_addr), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk($sformatf("wr_addr@%0d", k), 32'(wr_addr), 32'(e.addr));
            chk($sformatf("wr_data@%0d", k), 32'(wr_data), 32'(e.data));
         end
      end
   endtask

   // Called mid-cycle in IDLE; returns mid-cycle 0.
   task automatic start_op();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      load_vec(v);
      clear_written();
      push_expected();
      start_op();
      for (int k = 0; k <= 39; k++) begin
         check_cycle(k);
         @(negedge clk);
      end
      chk({tag, "_written"}, 32'(written), 32'h1FFFF);
      chk({tag, "_res0"}, 32'(res[0]), 32'(v.exp_w0));
      chk({tag, "_res16"}, 32'(res[16]), 32'(v.exp_w16));
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         check_cycle(39);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{a_base: 17'h00000, a_step: 17'h00001, b_base: 17'h00100, b_step: 17'h00001,
                  exp_w0: 17'h00100, exp_w16: 17'h00100};
      vecs[1] = '{a_base: 17'h1FFFF, a_step: 17'h00000, b_base: 17'h00000, b_step: 17'h00000,
                  exp_w0: 17'h1FFFF, exp_w16: 17'h1FFFF};
      vecs[2] = '{a_base: 17'h15555, a_step: 17'h00000, b_base: 17'h0AAAA, b_step: 17'h00000,
                  exp_w0: 17'h1FFFF, exp_w16: 17'h1FFFF};
      vecs[3] = '{a_base: 17'h1FFFF, a_step: 17'h1FFFF, b_base: 17'h00001, b_step: 17'h00002,
                  exp_w0: 17'h1FFFE, exp_w16: 17'h1FFCE};

      rst = 1'b1;
      start = 1'b0;
      load_vec(vecs[0]);
      repeat (3) @(negedge clk);
      check_cycle(39);
      rst = 1'b0;
      idle_cycles(100);

      for (int v = 0; v < 4; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

      // start held high: back-to-back operations, one per IDLE entry.
      load_vec(vecs[0]);
      clear_written();
      push_expected();
      push_expected();
      start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 80; k++) begin
         check_cycle(k % 40);
         if (k == 78) start = 1'b0;
         @(negedge clk);
      end
      chk("held_sb_empty", 32'(sb.size()), 32'd0);
      idle_cycles(3);

      // Reset during LOAD: nothing is written, no done.
      load_vec(vecs[3]);
      clear_written();
      start_op();
      for (int k = 0; k <= 10; k++) begin
         check_cycle(k);
         if (k < 10) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(40);
      chk("rst10_written", 32'(written), 32'h0);

      run_vec(vecs[0], "after_rst10");

      // Reset mid-UNLOAD: writes to 0,16,15,14,13 only.
      load_vec(vecs[3]);
      clear_written();
      push_expected();
      start_op();
      for (int k = 0; k <= 25; k++) begin
         check_cycle(k);
         if (k < 25) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(40);
      chk("rst25_written", 32'(written), 32'h1E001);
      chk("rst25_sb_left", 32'(sb.size()), 32'd12);
      sb.delete();

      run_vec(vecs[1], "after_rst25");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
